// File: rtl/fa_serial_addsub.sv
// fa_serial_addsub: bit-serial adder/subtractor built around one full-adder
// cell and a registered carry. Operands are accepted through a valid/ready
// handshake, processed LSB first at one bit per clock, and the WIDTH-bit
// result with carry-out and signed overflow is returned through a second
// valid/ready handshake.
//
// Optional feature macro: FA_SERIAL_SUB_EN
//   defined   - adds the 'sub' port; sub=1 at accept computes a - b - cin
//   undefined - add-only, no 'sub' port and no operand inversion
module fa_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef FA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;
    logic             out_valid_reg, out_valid_next;

    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    // The single full-adder cell operating on the current LSBs.
    assign s_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign c_bit    = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Operands shift right; the result bit enters the accumulator at the MSB
    // so that after WIDTH steps bit 0 has arrived at position 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign a_shift[gi]   = 1'b0;
                assign b_shift[gi]   = 1'b0;
                assign acc_shift[gi] = s_bit;
            end else begin : g_low
                assign a_shift[gi]   = a_reg[gi+1];
                assign b_shift[gi]   = b_reg[gi+1];
                assign acc_shift[gi] = acc_reg[gi+1];
            end
        end
    endgenerate

`ifdef FA_SERIAL_SUB_EN
    // Subtraction as a + ~b + ~cin: borrow-in becomes an inverted carry-in.
    assign b_load   = sub ? ~b : b;
    assign cin_load = cin ^ sub;
`else
    assign b_load   = b;
    assign cin_load = cin;
`endif

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

    // Next-state and datapath decode; every register holds unless updated.
    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        acc_next       = acc_reg;
        sum_next       = sum_reg;
        carry_next     = carry_reg;
        cnt_next       = cnt_reg;
        cout_next      = cout_reg;
        ovf_next       = ovf_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b_load;
                    carry_next = cin_load;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next     = a_shift;
                b_next     = b_shift;
                acc_next   = acc_shift;
                carry_next = c_bit;
                cnt_next   = cnt_reg + CW'(1);
                if (last_bit) begin
                    // carry_reg is the carry into the MSB, c_bit the carry out.
                    sum_next       = acc_shift;
                    cout_next      = c_bit;
                    ovf_next       = carry_reg ^ c_bit;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                out_valid_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            acc_reg       <= acc_next;
            sum_reg       <= sum_next;
            carry_reg     <= carry_next;
            cnt_reg       <= cnt_next;
            cout_reg      <= cout_next;
            ovf_reg       <= ovf_next;
            out_valid_reg <= out_valid_next;
        end
    end

endmodule

// File: tb/tb_fa_serial_addsub.sv
// Bench for fa_serial_addsub: an 8-bit instance driven with directed
// vectors and checked by an arithmetic model via a result queue, plus a
// 1-bit instance swept against the full-adder truth table.
module tb_fa_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    // 8-bit instance
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
    logic [7:0] a, b, sum;
    logic       sub;
    // 1-bit instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;
    logic       sub1;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];   // {ovf, cout, sum}

    always #5 clk = ~clk;

    fa_serial_addsub #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef FA_SERIAL_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    fa_serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef FA_SERIAL_SUB_EN
        .sub(sub1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    // Arithmetic model: subtraction is a + ~b + ~cin; overflow when both
    // addends share a sign that the result does not.
    function automatic logic [9:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mc, input logic ms);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] t;
        logic       v;
        bb = ms ? ~mb : mb;
        cc = ms ? ~mc : mc;
        t  = {1'b0, ma} + {1'b0, bb} + {8'd0, cc};
        v  = (ma[7] == bb[7]) && (t[7] != ma[7]);
        return {v, t[8], t[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding model result; it retires on the handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {22'd0, ovf, cout, sum}, 32'h3ff);
            end else begin
                chk("model_result", {22'd0, ovf, cout, sum}, {22'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Issue one 8-bit operation; called #1 after a rising edge.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic is, input logic lit, input logic [9:0] lexp,
                         input logic hold);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        a = ia; b = ib; cin = ic; sub = is;
        exp_q.push_back(model8(ia, ib, ic, is));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, 32'd8);
        if (lit) chk("literal_result", {22'd0, ovf, cout, sum}, {22'd0, lexp});
        if (!hold) begin
            @(posedge clk); #1;
            chk("return_to_idle", {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [1:0] tt [8];
        logic [7:0] held;
        logic [7:0] bad;
        tt = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        rst_n = 1'b0;
        in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
        in_valid1 = 0; out_ready1 = 1; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;

        // Pin the model against hand-computed values.
        chk("pin_0f_01", {22'd0, model8(8'h0F, 8'h01, 1'b0, 1'b0)}, 32'h010);
        chk("pin_ff_01_c", {22'd0, model8(8'hFF, 8'h01, 1'b1, 1'b0)}, 32'h101);
        chk("pin_7f_01", {22'd0, model8(8'h7F, 8'h01, 1'b0, 1'b0)}, 32'h280);
        chk("pin_sub_80_01", {22'd0, model8(8'h80, 8'h01, 1'b0, 1'b1)}, 32'h37F);

        #3;
        chk("reset_state", {20'd0, out_valid, in_ready, cout, ovf, sum}, {20'd0, 4'b0100, 8'h00});
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 10'h010, 1'b0);
        issue(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 10'h101, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 10'h280, 1'b0);
        issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 10'h300, 1'b0);
        issue(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 10'h100, 1'b0);
        issue(8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);

        // Backpressure: result held in DONE while new operands are offered.
        out_ready = 1'b0;
        issue(8'h3C, 8'h41, 1'b0, 1'b0, 1'b1, 10'h07D, 1'b1);
        held = sum;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = 8'h11 + 8'(k); b = 8'h22; cin = 1'b1;
            @(posedge clk); #1;
            chk("stall_hold", {22'd0, out_valid, in_ready, sum}, {22'd0, 2'b10, held});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {30'd0, out_valid, in_ready}, 32'd1);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("no_queued_operand", {24'd0, bad}, 32'd0);

        // Reset after bit 3 of a run.
        issue(8'hC3, 8'h3C, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
        a = 8'h55; b = 8'h66; cin = 1'b0; in_valid = 1'b1;
        exp_q.push_back(model8(8'h55, 8'h66, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_mid_run", {20'd0, out_valid, in_ready, cout, ovf, sum}, {20'd0, 4'b0100, 8'h00});
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(8'h02, 8'h03, 1'b0, 1'b0, 1'b1, 10'h005, 1'b0);

`ifdef FA_SERIAL_SUB_EN
        issue(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 10'h0FE, 1'b0);
        issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 10'h37F, 1'b0);
        issue(8'h30, 8'h10, 1'b1, 1'b1, 1'b1, 10'h11F, 1'b0);
`endif

        // WIDTH=1: full-adder truth table, index = {cin, a, b}.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] iv;
            iv = 3'(i);
            cin1 = iv[2]; a1 = iv[1]; b1 = iv[0];
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            @(posedge clk); #1;
            chk("w1_valid", {31'd0, out_valid1}, 32'd1);
            chk("w1_sum", {30'd0, cout1, sum1}, {30'd0, tt[i]});
            chk("w1_ovf", {31'd0, ovf1}, {31'd0, iv[2] ^ tt[i][1]});
            @(posedge clk); #1;
            chk("w1_idle", {30'd0, out_valid1, in_ready1}, 32'd1);
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
